// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Shares a single combinational Prefix_adder between NREQ requesters. One
// request is accepted at a time. Its operands are registered and run through
// the adder. The sum and carry are then returned, tagged with the requester
// ID, on a response channel.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A requester holds valid and its
// data stable until it sees ready. The arbiter holds the response fields stable
// while o_RSP_VALID is high and i_RSP_READY is low.
//
// Ports
//   i_CLK        clock, rising edge
//   i_RST_N      asynchronous active-low reset
//   i_REQ_VALID  [NREQ]        per-requester request valid
//   o_REQ_READY  [NREQ]        per-requester accept (one-hot or zero)
//   i_REQ_A      [NREQ*WIDTH]  operand A, requester k at [k*WIDTH +: WIDTH]
//   i_REQ_B      [NREQ*WIDTH]  operand B, same packing
//   i_REQ_CI     [NREQ]        carry-in per requester
//   o_RSP_VALID  response valid
//   i_RSP_READY  response consumer ready
//   o_RSP_SUM    [WIDTH]       registered sum
//   o_RSP_CO     registered carry-out
//   o_RSP_ID     [IDW]         requester that owns the response
//   o_DBG_STATE  [2]           FSM state (0 idle, 1 calc, 2 resp)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// Prefix_adder
//
// Kogge-Stone parallel-prefix adder. The carry-in is folded into the bit-0
// generate term. After the prefix tree, g[i] is therefore the carry out of bit i.
//
// Ports
//   a, b  [WIDTH]  operands
//   ci             carry-in
//   sum   [WIDTH]  (a + b + ci) mod 2^WIDTH
//   co             carry out of the top bit
// -----------------------------------------------------------------------------
module Prefix_adder #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] p0;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g_n;
   logic [WIDTH-1:0] p_n;
   logic [WIDTH-1:0] carry;

   always_comb begin
      p0    = a ^ b;
      g     = a & b;
      g[0]  = g[0] | (p0[0] & ci);
      p     = p0;
      g_n   = '0;
      p_n   = '0;
      carry = '0;

      // Each level combines every bit with the group 2^lv positions below it.
      for (int lv = 0; lv < LEVELS; lv++) begin
         g_n = g;
         p_n = p;
         for (int i = 0; i < WIDTH; i++) begin
            if (i >= (1 << lv)) begin
               g_n[i] = g[i] | (p[i] & g[i - (1 << lv)]);
               p_n[i] = p[i] & p[i - (1 << lv)];
            end
         end
         g = g_n;
         p = p_n;
      end

      carry[0] = ci;
      for (int i = 1; i < WIDTH; i++) begin
         carry[i] = g[i-1];
      end

      sum = p0 ^ carry;
      co  = g[WIDTH-1];
   end

endmodule

module adder_arbiter #(
   parameter  int WIDTH = 64,
   parameter  int NREQ  = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  i_CLK,
   input  logic                  i_RST_N,
   input  logic [NREQ-1:0]       i_REQ_VALID,
   output logic [NREQ-1:0]       o_REQ_READY,
   input  logic [NREQ*WIDTH-1:0] i_REQ_A,
   input  logic [NREQ*WIDTH-1:0] i_REQ_B,
   input  logic [NREQ-1:0]       i_REQ_CI,
   output logic                  o_RSP_VALID,
   input  logic                  i_RSP_READY,
   output logic [WIDTH-1:0]      o_RSP_SUM,
   output logic                  o_RSP_CO,
   output logic [IDW-1:0]        o_RSP_ID,
   output logic [1:0]            o_DBG_STATE
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   cand;
   logic [IDW-1:0]   win;
   logic             found;
   logic             accept;
   logic [NREQ-1:0]  req_ready;

   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             sel_ci;

   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic             op_ci_q;
   logic [IDW-1:0]   op_id_q;

   logic [WIDTH-1:0] add_sum;
   logic             add_co;

   logic             rsp_valid_q;
   logic [WIDTH-1:0] rsp_sum_q;
   logic             rsp_co_q;
   logic [IDW-1:0]   rsp_id_q;

   // Round-robin search starting one past the last winner. The modulo keeps
   // the search correct when NREQ is not a power of two.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(ptr_q) + k) % NREQ);
         if (!found && i_REQ_VALID[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_ci = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (win == IDW'(k)) begin
            sel_a  = i_REQ_A[k*WIDTH +: WIDTH];
            sel_b  = i_REQ_B[k*WIDTH +: WIDTH];
            sel_ci = i_REQ_CI[k];
         end
      end
   end

   // Ready depends only on state and request valids. A grant is therefore
   // also a completed handshake.
   always_comb begin
      req_ready = '0;
      accept    = 1'b0;
      if (state_q == S_IDLE && found) begin
         req_ready[win] = 1'b1;
         accept         = 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_CALC;
         S_CALC:  state_d = S_RESP;
         S_RESP:  if (i_RSP_READY) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   Prefix_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a   (op_a_q),
      .b   (op_b_q),
      .ci  (op_ci_q),
      .sum (add_sum),
      .co  (add_co)
   );

   // Operand and response registers. Reset in CALC or RESP clears the
   // response valid, so an in-flight request never produces a response.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         ptr_q       <= IDW'(NREQ - 1);
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_ci_q     <= 1'b0;
         op_id_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_co_q    <= 1'b0;
         rsp_id_q    <= '0;
      end else begin
         if (accept) begin
            op_a_q  <= sel_a;
            op_b_q  <= sel_b;
            op_ci_q <= sel_ci;
            op_id_q <= win;
            ptr_q   <= win;
         end
         if (state_q == S_CALC) begin
            rsp_sum_q   <= add_sum;
            rsp_co_q    <= add_co;
            rsp_id_q    <= op_id_q;
            rsp_valid_q <= 1'b1;
         end else if (state_q == S_RESP && i_RSP_READY) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign o_REQ_READY = req_ready;
   assign o_RSP_VALID = rsp_valid_q;
   assign o_RSP_SUM   = rsp_sum_q;
   assign o_RSP_CO    = rsp_co_q;
   assign o_RSP_ID    = rsp_id_q;
   assign o_DBG_STATE = state_q;

endmodule
